// File: rtl/instr_loader.sv
// instr_loader: byte-stream program loader for the multicycle MIPS instruction
// memory. Accepts a frame of {count_hi, count_lo, N x 4 big-endian data bytes
// [, checksum]} over a valid/ready handshake and writes each assembled 32-bit
// word to consecutive word slots, holding the CPU for the whole load.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the trailing XOR checksum
// byte, the CHK state and the XOR accumulator).
module instr_loader #(
  parameter int WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
`ifdef LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

  // Largest legal word count, widened so WORDS = 65536 would still compare.
  localparam logic [16:0] MAX_N = 17'(WORDS);

  state_t      state;
  logic [7:0]  count_hi;   // first header byte, kept until count_lo arrives
  logic [15:0] last_idx;   // N - 1: index of the final word
  logic [15:0] idx;        // word slot currently being assembled
  logic [1:0]  byte_cnt;   // bytes of the current word already received
  logic [23:0] word_acc;   // upper three bytes of the word being assembled
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  xor_acc;    // running XOR of every data byte
`endif

  logic        xfer;
  logic [15:0] hdr_n;
  logic        count_ok;

  assign xfer     = in_valid && in_ready;
  assign hdr_n    = {count_hi, in_data};
  assign count_ok = (hdr_n != 16'd0) && ({1'b0, hdr_n} <= MAX_N);

  // Loader FSM with all outputs registered; mem_we defaults to a one-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count_hi  <= 8'd0;
      last_idx  <= 16'd0;
      idx       <= 16'd0;
      byte_cnt  <= 2'd0;
      word_acc  <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
      xor_acc   <= 8'd0;
`endif
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= HDR_HI;
            count_hi <= 8'd0;
            last_idx <= 16'd0;
            idx      <= 16'd0;
            byte_cnt <= 2'd0;
            word_acc <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
            xor_acc  <= 8'd0;
`endif
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
          end
        end

        HDR_HI: begin
          if (xfer) begin
            count_hi <= in_data;
            state    <= HDR_LO;
          end
        end

        HDR_LO: begin
          if (xfer) begin
            if (count_ok) begin
              last_idx <= hdr_n - 16'd1;
              state    <= DATA;
            end else begin
              // Illegal count: stop accepting bytes but keep the core held.
              state    <= ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end
          end
        end

        DATA: begin
          if (xfer) begin
            word_acc <= {word_acc[15:0], in_data};
`ifdef LOADER_CHECKSUM_EN
            xor_acc  <= xor_acc ^ in_data;
`endif
            if (byte_cnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= {14'd0, idx, 2'b00};
              mem_wdata <= {word_acc, in_data};
              byte_cnt  <= 2'd0;
              if (idx == last_idx) begin
                // Final word: the index stays put so it never wraps past WORDS-1.
`ifdef LOADER_CHECKSUM_EN
                state    <= CHK;
`else
                state    <= DONE;
                in_ready <= 1'b0;
                cpu_hold <= 1'b0;
                done     <= 1'b1;
`endif
              end else begin
                idx <= idx + 16'd1;
              end
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_data == xor_acc) begin
              state    <= DONE;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed-vector bench for instr_loader. Writes are logged on
// the falling edge and compared against hand-computed addresses and words.
// Sections specific to LOADER_CHECKSUM_EN follow the same macro.
module tb_instr_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic        wr_done[$];
  logic        wr_hold[$];

  instr_loader #(.WORDS(1024)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every write strobe together with done/cpu_hold seen in the same cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_done.push_back(done);
      wr_hold.push_back(cpu_hold);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_done.delete();
    wr_hold.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Offer one byte and return right after the edge on which it transferred.
  task automatic send_byte(input logic [7:0] b);
    bit sent = 0;
    for (int i = 0; i < 20 && !sent; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      if (in_ready) begin
        @(posedge clk);
        sent = 1;
      end
    end
    if (!sent) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic wait_end();
    int i;
    @(negedge clk);
    in_valid = 1'b0;
    for (i = 0; i < 20 && !(done || error); i++) @(negedge clk);
    check("end_reached", {31'd0, done | error}, 32'd1);
    idle_cycles(2);
  endtask

  initial begin
    logic [7:0] frame[$];
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mem_we",   {31'd0, mem_we},   32'd0);
    check("rst_addr",     mem_addr,          32'd0);
    check("rst_wdata",    mem_wdata,         32'd0);
    check("rst_hold",     {31'd0, cpu_hold}, 32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_error",    {31'd0, error},    32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

`ifndef LOADER_CHECKSUM_EN
    // Basic two-word load
    clear_log();
    pulse_start();
    @(negedge clk);
    check("start_ready", {31'd0, in_ready}, 32'd1);
    check("start_hold",  {31'd0, cpu_hold}, 32'd1);
    frame = '{8'h00, 8'h02, 8'h80, 8'h01, 8'h06, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(frame);
    wait_end();
    check("basic_nwr", wr_addr.size(), 32'd2);
    if (wr_addr.size() == 2) begin
      check("basic_addr0", wr_addr[0], 32'h0);
      check("basic_data0", wr_data[0], 32'h8001060A);
      check("basic_done0", {31'd0, wr_done[0]}, 32'd0);
      check("basic_addr1", wr_addr[1], 32'h4);
      check("basic_data1", wr_data[1], 32'h0);
      check("basic_done1", {31'd0, wr_done[1]}, 32'd1);
      check("basic_hold1", {31'd0, wr_hold[1]}, 32'd0);
    end
    check("basic_done",  {31'd0, done},     32'd1);
    check("basic_error", {31'd0, error},    32'd0);
    check("basic_ready", {31'd0, in_ready}, 32'd0);
    check("basic_hold",  {31'd0, cpu_hold}, 32'd0);
    check("basic_addr_hold", mem_addr, 32'h4);

    // Stalled stream: in_valid low 3 cycles between bytes 2 and 3 of word 0
    clear_log();
    pulse_start();
    check("restart_done_clr", {31'd0, done}, 32'd0);
    frame = '{8'h00, 8'h02, 8'h80, 8'h01};
    send_frame(frame);
    idle_cycles(3);
    check("stall_nwr_mid", wr_addr.size(), 32'd0);
    frame = '{8'h06, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(frame);
    wait_end();
    check("stall_nwr", wr_addr.size(), 32'd2);
    if (wr_addr.size() == 2) begin
      check("stall_data0", wr_data[0], 32'h8001060A);
      check("stall_addr1", wr_addr[1], 32'h4);
      check("stall_data1", wr_data[1], 32'h0);
    end
    check("stall_done", {31'd0, done}, 32'd1);

    // start while busy in DATA is ignored
    clear_log();
    pulse_start();
    frame = '{8'h00, 8'h02, 8'h12, 8'h34};
    send_frame(frame);
    @(negedge clk);
    in_valid = 1'b0;
    pulse_start();
    frame = '{8'h56, 8'h78, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    send_frame(frame);
    wait_end();
    check("busy_nwr", wr_addr.size(), 32'd2);
    if (wr_addr.size() == 2) begin
      check("busy_addr0", wr_addr[0], 32'h0);
      check("busy_data0", wr_data[0], 32'h12345678);
      check("busy_addr1", wr_addr[1], 32'h4);
      check("busy_data1", wr_data[1], 32'hCAFEBABE);
    end
    check("busy_done", {31'd0, done}, 32'd1);
`else
    // Checksum good: 80^01^06^0A = 8D
    clear_log();
    pulse_start();
    frame = '{8'h00, 8'h01, 8'h80, 8'h01, 8'h06, 8'h0A, 8'h8D};
    send_frame(frame);
    wait_end();
    check("chk_ok_nwr",   wr_addr.size(), 32'd1);
    check("chk_ok_done",  {31'd0, done},  32'd1);
    check("chk_ok_error", {31'd0, error}, 32'd0);
    check("chk_ok_hold",  {31'd0, cpu_hold}, 32'd0);

    // Checksum bad
    clear_log();
    pulse_start();
    frame = '{8'h00, 8'h01, 8'h80, 8'h01, 8'h06, 8'h0A, 8'h8C};
    send_frame(frame);
    wait_end();
    check("chk_bad_nwr", wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) begin
      check("chk_bad_addr", wr_addr[0], 32'h0);
      check("chk_bad_data", wr_data[0], 32'h8001060A);
    end
    check("chk_bad_error", {31'd0, error},    32'd1);
    check("chk_bad_done",  {31'd0, done},     32'd0);
    check("chk_bad_hold",  {31'd0, cpu_hold}, 32'd1);
    check("chk_bad_ready", {31'd0, in_ready}, 32'd0);
`endif

    // Illegal counts: 0 and 1025
    clear_log();
    pulse_start();
    frame = '{8'h00, 8'h00};
    send_frame(frame);
    wait_end();
    check("cnt0_error", {31'd0, error},    32'd1);
    check("cnt0_hold",  {31'd0, cpu_hold}, 32'd1);
    check("cnt0_ready", {31'd0, in_ready}, 32'd0);
    check("cnt0_done",  {31'd0, done},     32'd0);
    pulse_start();
    frame = '{8'h04, 8'h01};
    send_frame(frame);
    wait_end();
    check("cnt1025_error", {31'd0, error},    32'd1);
    check("cnt1025_hold",  {31'd0, cpu_hold}, 32'd1);
    check("cnt1025_ready", {31'd0, in_ready}, 32'd0);
    check("illegal_nwr", wr_addr.size(), 32'd0);

    // Reset after 5 data bytes of a 3-word load, then restart
    pulse_start();
    frame = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame(frame);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_addr_data", mem_wdata, 32'h11223344);
    rst_n = 1'b0;
    #1;
    check("arst_ready", {31'd0, in_ready}, 32'd0);
    check("arst_we",    {31'd0, mem_we},   32'd0);
    check("arst_addr",  mem_addr,          32'd0);
    check("arst_wdata", mem_wdata,         32'd0);
    check("arst_hold",  {31'd0, cpu_hold}, 32'd0);
    check("arst_error", {31'd0, error},    32'd0);
    check("arst_done",  {31'd0, done},     32'd0);
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(2);
    clear_log();
    pulse_start();
`ifdef LOADER_CHECKSUM_EN
    frame = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
`else
    frame = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`endif
    send_frame(frame);
    wait_end();
    check("restart_nwr", wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) begin
      check("restart_addr", wr_addr[0], 32'h0);
      check("restart_data", wr_data[0], 32'hAABBCCDD);
    end
    check("restart_done", {31'd0, done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
